// File: rtl/nasti_dma_pkg.sv
// Shared types and constants for the NASTI DMA descriptor fetcher.
// A descriptor is four 64-bit words: src, dest, len (bytes), next pointer.
package nasti_dma_pkg;

    localparam int DESC_BEATS = 4;

    // AXI/NASTI burst encoding for incrementing bursts
    localparam logic [1:0] BURST_INCR = 2'b01;

    // err_code values
    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_RESP        = 2'd1;
    localparam logic [1:0] ERR_DESC_ALIGN  = 2'd2;
    localparam logic [1:0] ERR_FIELD_ALIGN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_AR = 3'd1,
        S_FETCH_R  = 3'd2,
        S_ISSUE    = 3'd3,
        S_DRAIN    = 3'd4
    } state_e;

    typedef struct packed {
        logic [63:0] src;
        logic [63:0] dest;
        logic [63:0] len;
        logic [63:0] next;
    } desc_t;

    // Descriptors live on 32-byte boundaries (one 4-beat burst of 64-bit words)
    function automatic logic desc_aligned(input logic [4:0] low_bits);
        return (low_bits == 5'd0);
    endfunction

endpackage

// File: rtl/nasti_dma_desc_fetch.sv
// Descriptor-chain fetcher: reads 32-byte descriptors over the NASTI ar/r
// channels and hands each non-empty one to a downstream data mover.
// Optional build macro: NASTI_DESC_ALIGN_CHECK_EN enables 8-byte alignment
// checking of src/dest/len before a descriptor is issued.
//
// Handshakes: every valid/ready pair transfers on a rising aclk edge where
// both are high; a source holds valid and its payload stable until then.
module nasti_dma_desc_fetch
    import nasti_dma_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   aclk,
    input  logic                   areset,
    // chain start
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic                   start_valid,
    output logic                   start_ready,
    // NASTI read address channel
    output logic                   ar_valid,
    input  logic                   ar_ready,
    output logic [ADDR_WIDTH-1:0]  ar_addr,
    output logic [7:0]             ar_len,
    output logic [2:0]             ar_size,
    output logic [1:0]             ar_burst,
    output logic [3:0]             ar_id,
    output logic [3:0]             ar_cache,
    output logic [2:0]             ar_prot,
    output logic                   ar_lock,
    // NASTI read data channel
    input  logic                   r_valid,
    output logic                   r_ready,
    input  logic [DATA_WIDTH-1:0]  r_data,
    input  logic [1:0]             r_resp,
    input  logic                   r_last,
    // unused write side of the NASTI port
    output logic                   aw_valid,
    output logic                   w_valid,
    output logic                   b_ready,
    // data mover request
    output logic [ADDR_WIDTH-1:0]  m_src,
    output logic [ADDR_WIDTH-1:0]  m_dest,
    output logic [ADDR_WIDTH-1:0]  m_len,
    output logic                   m_valid,
    input  logic                   m_ready,
    // status
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code,
    output logic [COUNT_WIDTH-1:0] desc_count,
    output logic [2:0]             state_dbg
);

    state_e                state, state_nxt;
    desc_t                 desc_q;
    logic [ADDR_WIDTH-1:0] desc_addr;
    logic [1:0]            beat_cnt;
    logic                  rd_bad;
    logic                  hs_last;
    logic                  drain_first;

    logic                  start_ok, start_bad;
    logic                  done_nxt, err_set, cnt_inc, follow_next;
    logic [1:0]            err_val;
    logic                  field_bad;

    logic [63:0]           word_in;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] len_val;

    assign word_in   = 64'(r_data);
    assign next_addr = ADDR_WIDTH'(desc_q.next);
    assign len_val   = ADDR_WIDTH'(desc_q.len);

`ifdef NASTI_DESC_ALIGN_CHECK_EN
    assign field_bad = (desc_q.src[2:0] != 3'd0) || (desc_q.dest[2:0] != 3'd0) ||
                       (desc_q.len[2:0] != 3'd0);
`else
    assign field_bad = 1'b0;
`endif

    // Fixed read-burst shape and the unused write channel
    assign ar_addr   = desc_addr;
    assign ar_len    = 8'(DESC_BEATS - 1);
    assign ar_size   = 3'b011;
    assign ar_burst  = BURST_INCR;
    assign ar_id     = 4'd0;
    assign ar_cache  = 4'd0;
    assign ar_prot   = 3'd0;
    assign ar_lock   = 1'b0;
    assign aw_valid  = 1'b0;
    assign w_valid   = 1'b0;
    assign b_ready   = 1'b0;

    assign m_src     = ADDR_WIDTH'(desc_q.src);
    assign m_dest    = ADDR_WIDTH'(desc_q.dest);
    assign m_len     = len_val;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state, handshake outputs and per-cycle status events
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        ar_valid    = 1'b0;
        r_ready     = 1'b0;
        m_valid     = 1'b0;
        start_ok    = 1'b0;
        start_bad   = 1'b0;
        done_nxt    = 1'b0;
        err_set     = 1'b0;
        err_val     = ERR_NONE;
        cnt_inc     = 1'b0;
        follow_next = 1'b0;
        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    if (!desc_aligned(start_addr[4:0])) begin
                        start_bad = 1'b1;
                        err_set   = 1'b1;
                        err_val   = ERR_DESC_ALIGN;
                        done_nxt  = 1'b1;
                    end else begin
                        start_ok  = 1'b1;
                        state_nxt = S_FETCH_AR;
                    end
                end
            end
            S_FETCH_AR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_nxt = S_FETCH_R;
            end
            S_FETCH_R: begin
                r_ready = 1'b1;
                // any bad beat or wrong burst length is reported once r_last arrives
                if (r_valid && r_last) begin
                    if (rd_bad || (r_resp != 2'b00) || (beat_cnt != 2'(DESC_BEATS - 1))) begin
                        err_set   = 1'b1;
                        err_val   = ERR_RESP;
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (field_bad) begin
                    err_set   = 1'b1;
                    err_val   = ERR_FIELD_ALIGN;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (len_val == '0) begin
                    if (next_addr == '0) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (!desc_aligned(next_addr[4:0])) begin
                        err_set   = 1'b1;
                        err_val   = ERR_DESC_ALIGN;
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        follow_next = 1'b1;
                        state_nxt   = S_FETCH_AR;
                    end
                end else begin
                    // hold off for one cycle after a handshake so a mover that
                    // has not yet dropped m_ready is not mistaken for idle
                    m_valid = !hs_last;
                    if (m_valid && m_ready) begin
                        cnt_inc = 1'b1;
                        if (next_addr == '0) begin
                            state_nxt = S_DRAIN;
                        end else if (!desc_aligned(next_addr[4:0])) begin
                            err_set   = 1'b1;
                            err_val   = ERR_DESC_ALIGN;
                            done_nxt  = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            follow_next = 1'b1;
                            state_nxt   = S_FETCH_AR;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // the m_ready seen right after the last handshake is stale
                if (!drain_first && m_ready) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Descriptor address, burst capture and handshake history
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            desc_addr   <= '0;
            desc_q      <= '0;
            beat_cnt    <= 2'd0;
            rd_bad      <= 1'b0;
            hs_last     <= 1'b0;
            drain_first <= 1'b0;
        end else begin
            if (start_ok)         desc_addr <= start_addr;
            else if (follow_next) desc_addr <= next_addr;

            if (ar_valid && ar_ready) begin
                beat_cnt <= 2'd0;
                rd_bad   <= 1'b0;
            end else if (r_ready && r_valid) begin
                case (beat_cnt)
                    2'd0:    desc_q.src  <= word_in;
                    2'd1:    desc_q.dest <= word_in;
                    2'd2:    desc_q.len  <= word_in;
                    default: desc_q.next <= word_in;
                endcase
                if (beat_cnt != 2'(DESC_BEATS - 1)) beat_cnt <= beat_cnt + 2'd1;
                // a bad response, or a burst running past its fourth beat
                if ((r_resp != 2'b00) || (!r_last && (beat_cnt == 2'(DESC_BEATS - 1))))
                    rd_bad <= 1'b1;
            end

            hs_last     <= m_valid && m_ready;
            drain_first <= (state != S_DRAIN) && (state_nxt == S_DRAIN);
        end
    end

    // Status outputs: done pulse, sticky error and descriptor counter
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            desc_count <= '0;
        end else begin
            done <= done_nxt;
            if (err_set) begin
                error    <= 1'b1;
                err_code <= err_val;
            end else if (start_ok) begin
                error    <= 1'b0;
                err_code <= ERR_NONE;
            end
            if (start_ok || start_bad)
                desc_count <= '0;
            else if (cnt_inc && (desc_count != '1))
                desc_count <= desc_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_nasti_dma_desc_fetch.sv
// Bench for nasti_dma_desc_fetch: memory-backed NASTI read slave, random
// mover, and a chain-walking reference model feeding expected queues.
module tb_nasti_dma_desc_fetch;
    import nasti_dma_pkg::*;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] start_addr;
    logic          start_valid, start_ready;
    logic          ar_valid, ar_ready;
    logic [AW-1:0] ar_addr;
    logic [7:0]    ar_len;
    logic [2:0]    ar_size;
    logic [1:0]    ar_burst;
    logic [3:0]    ar_id, ar_cache;
    logic [2:0]    ar_prot;
    logic          ar_lock;
    logic          r_valid, r_ready, r_last;
    logic [DW-1:0] r_data;
    logic [1:0]    r_resp;
    logic          aw_valid, w_valid, b_ready;
    logic [AW-1:0] m_src, m_dest, m_len;
    logic          m_valid, m_ready;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [CW-1:0] desc_count;
    logic [2:0]    state_dbg;

    // clock / reset
    always #5 aclk = ~aclk;

    nasti_dma_desc_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .aclk(aclk), .areset(areset),
        .start_addr(start_addr), .start_valid(start_valid), .start_ready(start_ready),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst), .ar_id(ar_id), .ar_cache(ar_cache),
        .ar_prot(ar_prot), .ar_lock(ar_lock),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .aw_valid(aw_valid), .w_valid(w_valid), .b_ready(b_ready),
        .m_src(m_src), .m_dest(m_dest), .m_len(m_len), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .desc_count(desc_count), .state_dbg(state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    // scoreboard queues
    logic [63:0]  exp_ar_q[$];
    logic [191:0] exp_m_q[$];
    logic [18:0]  exp_done_q[$];   // {error, err_code, desc_count}

    // memory image and read-error injection
    logic [63:0] mem [logic [63:0]];
    logic [63:0] err_desc = 64'h0;
    int          err_beat = -1;

    logic [63:0] burst_q[$];
    int          beat = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    task automatic write_desc(input logic [63:0] a, input logic [63:0] s, input logic [63:0] d,
                              input logic [63:0] l, input logic [63:0] n);
        mem[a] = s; mem[a + 64'd8] = d; mem[a + 64'd16] = l; mem[a + 64'd24] = n;
    endtask

    // Reference model: walk the chain in memory and push every expected
    // fetch, mover request and the final status.
    task automatic model(input logic [63:0] start);
        logic [63:0] a, s, d, l, n;
        int cnt;
        cnt = 0;
        if (start[4:0] != 5'd0) begin
            exp_done_q.push_back({1'b1, 2'd2, 16'd0});
            return;
        end
        a = start;
        for (int guard = 0; guard < 64; guard++) begin
            exp_ar_q.push_back(a);
            s = rd(a); d = rd(a + 64'd8); l = rd(a + 64'd16); n = rd(a + 64'd24);
            if (err_beat >= 0 && a == err_desc) begin
                exp_done_q.push_back({1'b1, 2'd1, 16'(cnt)});
                return;
            end
`ifdef NASTI_DESC_ALIGN_CHECK_EN
            if ((s[2:0] | d[2:0] | l[2:0]) != 3'd0) begin
                exp_done_q.push_back({1'b1, 2'd3, 16'(cnt)});
                return;
            end
`endif
            if (l != 64'd0) begin
                exp_m_q.push_back({s, d, l});
                cnt++;
            end
            if (n == 64'd0) begin
                exp_done_q.push_back({1'b0, 2'd0, 16'(cnt)});
                return;
            end
            if (n[4:0] != 5'd0) begin
                exp_done_q.push_back({1'b1, 2'd2, 16'(cnt)});
                return;
            end
            a = n;
        end
    endtask

    // AR slave: random ready, checks every accepted address
    initial begin
        ar_ready = 1'b0;
        forever begin
            @(negedge aclk);
            ar_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (!areset && ar_valid && ar_ready) begin
                if (exp_ar_q.size() == 0) check("ar_unexpected", {ar_valid, ar_addr}, 0);
                else check("ar_addr", ar_addr, exp_ar_q.pop_front());
                check("ar_fields", {ar_len, ar_size, ar_burst, ar_id, ar_cache, ar_prot, ar_lock},
                      {8'd3, 3'b011, 2'b01, 4'd0, 4'd0, 3'd0, 1'b0});
                burst_q.push_back(ar_addr);
            end
        end
    end

    // R slave: returns four beats per burst with random gaps
    initial begin
        logic [63:0] cur_a;
        bit r_fire;
        r_fire = 0;
        r_valid = 1'b0; r_last = 1'b0; r_data = '0; r_resp = 2'b00;
        forever begin
            @(negedge aclk);
            if (areset) begin
                burst_q.delete();
                beat = 0; r_fire = 0; r_valid = 1'b0;
            end else begin
                if (r_fire) begin
                    beat++;
                    if (beat == 4) begin
                        void'(burst_q.pop_front());
                        beat = 0;
                    end
                end
                if (burst_q.size() > 0) begin
                    cur_a   = burst_q[0];
                    r_valid = ($urandom_range(0, 3) != 0);
                    r_data  = rd(cur_a + 64'(8 * beat));
                    r_resp  = (err_beat == beat && cur_a == err_desc) ? 2'b10 : 2'b00;
                    r_last  = (beat == 3);
                end else begin
                    r_valid = 1'b0;
                end
                #1;
                r_fire = r_valid && r_ready && !areset;
            end
        end
    end

    // Mover: random ready, checks every accepted request
    initial begin
        m_ready = 1'b0;
        forever begin
            @(negedge aclk);
            m_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (!areset && m_valid && m_ready) begin
                if (exp_m_q.size() == 0) check("m_unexpected", {m_src, m_dest, m_len}, 0);
                else check("m_req", {m_src, m_dest, m_len}, exp_m_q.pop_front());
            end
        end
    end

    // Done monitor: final status against the model
    initial begin
        forever begin
            @(negedge aclk);
            #1;
            if (!areset && done) begin
                done_cnt++;
                if (exp_done_q.size() == 0) check("done_unexpected", done, 0);
                else check("done_status", {error, err_code, desc_count}, exp_done_q.pop_front());
            end
        end
    end

    // driver: start one chain and wait for its done pulse
    task automatic run_chain(input logic [63:0] a);
        int d0;
        d0 = done_cnt;
        model(a);
        @(negedge aclk);
        start_addr  = a;
        start_valid = 1'b1;
        #1;
        check("start_ready_idle", start_ready, 1);
        @(negedge aclk);
        start_valid = 1'b0;
        #2;
        if (a[4:0] == 5'd0) begin
            check("start_clears_error", {error, err_code, desc_count}, 0);
            check("busy_after_start", busy, 1);
        end
        for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
            @(negedge aclk);
            #2;
        end
        if (done_cnt == d0) check("done_timeout", 0, 1);
        check("busy_at_done", busy, 0);
        check("queues_drained", {exp_ar_q.size(), exp_m_q.size(), exp_done_q.size()}, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, state_dbg, S_IDLE);
        check({tag, "_hs"}, {start_ready, m_valid, ar_valid, done, busy}, 5'b10000);
        check({tag, "_status"}, {error, err_code, desc_count}, 0);
        check({tag, "_mreq"}, {m_src, m_dest, m_len}, 0);
        check({tag, "_ar_addr"}, ar_addr, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] addrs[4];
        logic [63:0] base, s, d, l, n, st;
        int nd, d0;

        areset = 1'b1; start_valid = 1'b0; start_addr = '0;
        repeat (3) @(negedge aclk);
        #1;
        check_reset_vals("reset");
        check("write_side_tied", {aw_valid, w_valid, b_ready}, 0);
        areset = 1'b0;

        // single descriptor
        write_desc(64'h1000, 64'h2000, 64'h3000, 64'h800, 64'h0);
        run_chain(64'h1000);

        // three-link chain with an empty middle descriptor
        write_desc(64'h1000, 64'h2000, 64'h3000, 64'h40, 64'h1020);
        write_desc(64'h1020, 64'h2100, 64'h3100, 64'h0, 64'h1040);
        write_desc(64'h1040, 64'h2200, 64'h3200, 64'h100, 64'h0);
        d0 = done_cnt;
        run_chain(64'h1000);
        repeat (4) @(negedge aclk);
        check("single_done_pulse", done_cnt - d0, 1);

        // SLVERR on beat 1
        write_desc(64'h1000, 64'h2000, 64'h3000, 64'h800, 64'h0);
        err_desc = 64'h1000; err_beat = 1;
        run_chain(64'h1000);
        err_beat = -1;
        repeat (4) @(negedge aclk);
        check("burst_fully_consumed", burst_q.size(), 0);

        // misaligned start, then a good start clears the error
        run_chain(64'h1008);
        run_chain(64'h1000);

        // reset during the read burst after two beats
        model(64'h1000);
        @(negedge aclk);
        start_addr = 64'h1000; start_valid = 1'b1;
        @(negedge aclk);
        start_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            #2;
            if (beat == 2 && burst_q.size() > 0) break;
        end
        check("reached_mid_burst", beat, 2);
        areset = 1'b1;
        #1;
        check_reset_vals("midburst_reset");
        exp_ar_q.delete(); exp_m_q.delete(); exp_done_q.delete();
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        run_chain(64'h1000);

        // unaligned length: issued unless the field check is built in
        write_desc(64'h1000, 64'h2000, 64'h3000, 64'h804, 64'h0);
        run_chain(64'h1000);

        // randomized chains
        for (int it = 0; it < 20; it++) begin
            base = 64'h10000 + 64'(it) * 64'h1000;
            nd = $urandom_range(1, 4);
            for (int k = 0; k < nd; k++)
                addrs[k] = base + 64'(k) * 64'h100 + 64'($urandom_range(0, 3) * 32);
            for (int k = 0; k < nd; k++) begin
                s = {$urandom, $urandom};
                d = {$urandom, $urandom};
                if ($urandom_range(0, 5) != 0) begin
                    s[2:0] = 3'd0; d[2:0] = 3'd0;
                end
                l = ($urandom_range(0, 3) == 0) ? 64'h0 : 64'($urandom_range(1, 4096) * 8);
                n = (k == nd - 1) ? 64'h0 : addrs[k + 1];
                if (k == nd - 1 && $urandom_range(0, 7) == 0) n = base + 64'hF08;
                write_desc(addrs[k], s, d, l, n);
            end
            if ($urandom_range(0, 5) == 0) begin
                err_desc = addrs[$urandom_range(0, nd - 1)];
                err_beat = $urandom_range(0, 3);
            end else begin
                err_beat = -1;
            end
            st = ($urandom_range(0, 9) == 0) ? addrs[0] + 64'h8 : addrs[0];
            run_chain(st);
        end
        err_beat = -1;

        repeat (5) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nasti_dma_desc_fetch.md
NASTI_DMA_DESC_FETCH -- requirements
Module: nasti_dma_desc_fetch

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 64, address width; DATA_WIDTH, default 64, NASTI data width; COUNT_WIDTH, default 16, descriptor counter width.
REQ-002 aclk  input  1  sole clock; all state updates on rising edge.
REQ-003 areset  input  1  asynchronous, active-high reset.
REQ-004 start_addr  input  ADDR_WIDTH  address of first descriptor in chain.
REQ-005 start_valid / start_ready  input / output  1  chain-start handshake; fires when both are high on a rising edge.
REQ-006 mem  nasti_channel  --  NASTI master; only the ar and r channels are used; aw_valid, w_valid and b_ready SHALL be tied to 0.
REQ-007 m_src, m_dest, m_len  output  ADDR_WIDTH each  request to the downstream data mover.
REQ-008 m_valid / m_ready  output / input  1  mover request handshake; m_ready high means the mover is idle and accepting.
REQ-009 busy  output  1  high whenever the block is not IDLE.
REQ-010 done  output  1  one-cycle pulse when a chain completes.
REQ-011 error  output  1  sticky error flag, cleared by the next accepted start.
REQ-012 err_code  output  2  error cause: 0 = none, 1 = bad read response, 2 = misaligned descriptor, 3 = misaligned field.
REQ-013 desc_count  output  COUNT_WIDTH  descriptors issued since the last start; saturates at all-ones.

Function
REQ-014 A descriptor SHALL be 4 consecutive 64-bit words: word0 src, word1 dest, word2 len in bytes, word3 next descriptor address; next = 0 terminates the chain.
REQ-015 States SHALL be IDLE, FETCH_AR, FETCH_R, ISSUE, DRAIN.
REQ-016 IDLE: start_ready = 1; on start fire the block SHALL:
- latch start_addr;
- clear error, err_code and desc_count;
- go to FETCH_AR.
REQ-017 In IDLE, if start_addr[4:0] != 0, the block SHALL instead set error, set err_code = 2, pulse done, and stay in IDLE.
REQ-018 FETCH_AR SHALL drive:
- ar_valid = 1, ar_addr = descriptor address;
- ar_len = 3, ar_size = 3'b011, ar_burst = INCR;
- ar_id, ar_cache, ar_prot, ar_lock = 0.
ar_valid is held until ar_ready; then go to FETCH_R.
REQ-019 FETCH_R: r_ready = 1; beat k (0..3) is stored to word k. On the beat with r_last, go to ISSUE; if r_last arrives before beat 3 or after it, treat as err_code 1.
REQ-020 If any beat has r_resp != 0, the block SHALL consume the remaining beats through r_last, then set error, err_code = 1, pulse done, and return to IDLE.
REQ-021 ISSUE with len == 0: no request is issued; next != 0 goes to FETCH_AR at next, else done pulse and IDLE.
REQ-022 ISSUE with len != 0: m_valid = 1 with m_src/m_dest/m_len stable until m_ready. On the handshake cycle:
- desc_count increments;
- next != 0 goes to FETCH_AR at next;
- next == 0 goes to DRAIN.
REQ-023 The first FETCH_AR after a handshake MAY overlap the mover's transfer. ISSUE SHALL NOT assert m_valid until the mover has dropped and re-raised m_ready, or one full cycle has passed since the last handshake.
REQ-024 DRAIN: ignore m_ready on the first cycle; afterwards, m_ready = 1 pulses done and returns to IDLE.
REQ-025 A next pointer with next[4:0] != 0 SHALL cause error, err_code = 2, a done pulse and IDLE, with no fetch of that pointer.
REQ-026 All address arithmetic is ADDR_WIDTH wide, unsigned, modulo 2^ADDR_WIDTH.

Reset
REQ-027 areset SHALL force the following, at any time including mid-burst, with no completion of outstanding beats:
- state IDLE;
- start_ready = 1;
- m_valid, ar_valid, done, error = 0; err_code = 0; desc_count = 0;
- m_src, m_dest, m_len, ar_addr = 0.

Configuration
REQ-028 With NASTI_DESC_ALIGN_CHECK_EN defined, ISSUE SHALL check src[2:0], dest[2:0] and len[2:0]; any nonzero value sets error, err_code = 3, pulses done and returns to IDLE without issuing.
REQ-029 Without NASTI_DESC_ALIGN_CHECK_EN, fields are passed unchecked and err_code 3 never occurs.

Structure
REQ-030 The package nasti_dma_pkg SHALL hold the descriptor struct (src, dest, len, next), the state enum, the err_code constants, and DESC_BEATS = 4.
REQ-031 There is no sub-module; the block is a single module.

Verification
REQ-032 Single descriptor at 0x1000 = {0x2000, 0x3000, 0x800, 0}, OKAY responses -> one ar with addr 0x1000, len 3; one m_valid with those values; done after m_ready returns; desc_count = 1.
REQ-033 Chain 0x1000 -> 0x1020 -> 0x1040 (lengths 0x40, 0, 0x100) -> three fetches; two issues; desc_count = 2; single done pulse.
REQ-034 SLVERR on beat 1 -> all 4 beats consumed; no m_valid; error = 1, err_code = 1; IDLE.
REQ-035 start_addr = 0x1008 -> error, err_code = 2; no ar issued. A following start at 0x1000 clears error.
REQ-036 areset asserted in FETCH_R after 2 beats -> all outputs at reset values next edge; start_ready = 1.
REQ-037 With NASTI_DESC_ALIGN_CHECK_EN defined, len = 0x804 -> err_code = 3 and no issue; without the macro -> m_len = 0x804 is issued.
